// File: rtl/line_buffer_control_if.sv
// Pixel stream, line-buffer strobes/data and filter-window bus around line_buffer_control.
// master = the controller, slave = the surrounding line buffers, pixel source and filter stage.
interface line_buffer_control_if;
    logic [7:0]  pixel_in;
    logic        pixel_in_valid;
    logic [3:0]  lb_in_valid;
    logic [3:0]  lb_read;
    logic [23:0] lb_data0;
    logic [23:0] lb_data1;
    logic [23:0] lb_data2;
    logic [23:0] lb_data3;
    logic [71:0] pixel_window;
    logic        pixel_window_valid;
    logic        line_done_intr;

    modport master (
        input  pixel_in,
        input  pixel_in_valid,
        input  lb_data0,
        input  lb_data1,
        input  lb_data2,
        input  lb_data3,
        output lb_in_valid,
        output lb_read,
        output pixel_window,
        output pixel_window_valid,
        output line_done_intr
    );

    modport slave (
        output pixel_in,
        output pixel_in_valid,
        output lb_data0,
        output lb_data1,
        output lb_data2,
        output lb_data3,
        input  lb_in_valid,
        input  lb_read,
        input  pixel_window,
        input  pixel_window_valid,
        input  line_done_intr
    );
endinterface

// File: rtl/line_buffer_control.sv
// Sequencer for four line buffers: steers input lines round-robin, reads three adjacent
// buffers in lockstep to form a 3-row pixel column, and pulses an interrupt per read line.
module line_buffer_control #(
    parameter int unsigned IMAGE_WIDTH = 512,
    parameter int unsigned IW_BIT_NUM  = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    line_buffer_control_if.master bus
);
    localparam int unsigned TOTAL_W = IW_BIT_NUM + 3;
    localparam logic [IW_BIT_NUM-1:0] LAST_PIX    = IW_BIT_NUM'(IMAGE_WIDTH - 1);
    localparam logic [TOTAL_W-1:0]    READ_THRESH = TOTAL_W'(3 * IMAGE_WIDTH);

    if ((64'(1) << IW_BIT_NUM) < 64'(IMAGE_WIDTH)) begin : g_width_check
        $error("IW_BIT_NUM too small to count IMAGE_WIDTH pixels");
    end

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IW_BIT_NUM-1:0]   wr_cnt_q, wr_cnt_d;
    logic [1:0]              wr_sel_q, wr_sel_d;
    logic [IW_BIT_NUM-1:0]   rd_cnt_q, rd_cnt_d;
    logic [1:0]              rd_sel_q, rd_sel_d;
    logic [TOTAL_W-1:0]      total_cnt_q, total_cnt_d;
    logic                    line_done_intr_q, line_done_intr_d;

    logic                    wr_fire;
    logic                    rd_fire;
    logic [1:0]              row_top;
    logic [1:0]              row_mid;
    logic [1:0]              row_bot;
    logic [23:0]             lb_data [4];

    // A write held during reset must not reach a buffer, so the strobe is gated by reset.
    assign wr_fire = bus.pixel_in_valid && !reset;
    assign rd_fire = (state_q == READ);

    // Next-state: write pointer, occupancy, and the read sequencer.
    always_comb begin
        state_d          = state_q;
        wr_cnt_d         = wr_cnt_q;
        wr_sel_d         = wr_sel_q;
        rd_cnt_d         = rd_cnt_q;
        rd_sel_d         = rd_sel_q;
        total_cnt_d      = total_cnt_q;
        line_done_intr_d = 1'b0;

        if (wr_fire) begin
            if (wr_cnt_q == LAST_PIX) begin
                wr_cnt_d = '0;
                wr_sel_d = wr_sel_q + 2'd1;
            end else begin
                wr_cnt_d = wr_cnt_q + IW_BIT_NUM'(1);
            end
        end

        unique case ({wr_fire, rd_fire})
            2'b10:   total_cnt_d = total_cnt_q + TOTAL_W'(1);
            2'b01:   total_cnt_d = total_cnt_q - TOTAL_W'(1);
            default: total_cnt_d = total_cnt_q;
        endcase

        unique case (state_q)
            IDLE: begin
                if (total_cnt_q >= READ_THRESH) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (rd_cnt_q == LAST_PIX) begin
                    rd_cnt_d         = '0;
                    rd_sel_d         = rd_sel_q + 2'd1;
                    state_d          = IDLE;
                    line_done_intr_d = 1'b1;
                end else begin
                    rd_cnt_d = rd_cnt_q + IW_BIT_NUM'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            wr_cnt_q         <= '0;
            wr_sel_q         <= '0;
            rd_cnt_q         <= '0;
            rd_sel_q         <= '0;
            total_cnt_q      <= '0;
            line_done_intr_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_cnt_q         <= wr_cnt_d;
            wr_sel_q         <= wr_sel_d;
            rd_cnt_q         <= rd_cnt_d;
            rd_sel_q         <= rd_sel_d;
            total_cnt_q      <= total_cnt_d;
            line_done_intr_q <= line_done_intr_d;
        end
    end

    // Read rows: the oldest unread line is on top, the two following buffers below it.
    assign row_top = rd_sel_q;
    assign row_mid = rd_sel_q + 2'd1;
    assign row_bot = rd_sel_q + 2'd2;

    assign lb_data[0] = bus.lb_data0;
    assign lb_data[1] = bus.lb_data1;
    assign lb_data[2] = bus.lb_data2;
    assign lb_data[3] = bus.lb_data3;

    assign bus.lb_in_valid = wr_fire ? (4'b0001 << wr_sel_q) : 4'b0000;
    assign bus.lb_read     = rd_fire
                           ? ((4'b0001 << row_top) | (4'b0001 << row_mid) | (4'b0001 << row_bot))
                           : 4'b0000;

    assign bus.pixel_window       = {lb_data[row_top], lb_data[row_mid], lb_data[row_bot]};
    assign bus.pixel_window_valid = rd_fire;
    assign bus.line_done_intr     = line_done_intr_q;
endmodule

// File: tb/tb_line_buffer_control.sv
// Directed bench for line_buffer_control at IMAGE_WIDTH=8, with four behavioural line buffers
// providing the 3-pixel outputs and a negedge monitor logging every window and interrupt.
module tb_line_buffer_control;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    line_buffer_control_if bus ();

    line_buffer_control #(
        .IMAGE_WIDTH (W),
        .IW_BIT_NUM  (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural line buffers: circular write pointer, read pointer advanced by lb_read.
    logic [7:0]  mem [4][8];
    logic [2:0]  wp  [4];
    logic [2:0]  rp  [4];
    logic [23:0] lbd [4];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                wp[i] <= 3'd0;
                rp[i] <= 3'd0;
            end else begin
                if (bus.lb_in_valid[i]) begin
                    mem[i][wp[i]] <= bus.pixel_in;
                    wp[i]         <= wp[i] + 3'd1;
                end
                if (bus.lb_read[i]) rp[i] <= rp[i] + 3'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lbd[i] = {mem[i][rp[i]], mem[i][rp[i] + 3'd1], mem[i][rp[i] + 3'd2]};
        end
    end

    assign bus.lb_data0 = lbd[0];
    assign bus.lb_data1 = lbd[1];
    assign bus.lb_data2 = lbd[2];
    assign bus.lb_data3 = lbd[3];

    typedef struct packed {
        int          cyc;
        logic [3:0]  rd;
        logic [23:0] px;
    } rec_t;

    rec_t rec_q[$];
    int   intr_cyc_q[$];
    int   intr_cnt = 0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Log the leading pixel of each row for every valid window, and every interrupt pulse.
    always @(negedge clk) begin
        if (bus.pixel_window_valid === 1'b1) begin
            rec_q.push_back('{cyc, bus.lb_read,
                             {bus.pixel_window[71:64], bus.pixel_window[47:40], bus.pixel_window[23:16]}});
        end
        if (bus.line_done_intr === 1'b1) begin
            intr_cnt <= intr_cnt + 1;
            intr_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Leading pixels of window j of read line r when line n holds values base+8n .. base+8n+7.
    function automatic logic [23:0] exp_px(int base, int r, int j);
        return {8'(base + 8*r + j), 8'(base + 8*r + 8 + j), 8'(base + 8*r + 16 + j)};
    endfunction

    function automatic logic [3:0] exp_rd(int r);
        case (r % 4)
            0:       return 4'b0111;
            1:       return 4'b1110;
            2:       return 4'b1101;
            default: return 4'b1011;
        endcase
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset              = 1'b1;
        bus.pixel_in_valid = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    // Drive n consecutive pixels base..base+n-1, then drop valid; returns just after the last write edge.
    task automatic feed(int n, int base);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.pixel_in       = 8'(base + k);
            bus.pixel_in_valid = 1'b1;
        end
        @(negedge clk);
        bus.pixel_in_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset              = 1'b1;
        bus.pixel_in       = 8'hAA;
        bus.pixel_in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (bus.lb_in_valid !== 4'b0000) $display("FAIL reset_lb_in_valid: got %b expected 0000", bus.lb_in_valid); else n_pass++;
            n_checks++; if (bus.lb_read !== 4'b0000) $display("FAIL reset_lb_read: got %b expected 0000", bus.lb_read); else n_pass++;
            n_checks++; if (bus.pixel_window_valid !== 1'b0) $display("FAIL reset_window_valid: got %b expected 0", bus.pixel_window_valid); else n_pass++;
            n_checks++; if (bus.line_done_intr !== 1'b0) $display("FAIL reset_intr: got %b expected 0", bus.line_done_intr); else n_pass++;
        end
        reset = 1'b0;
        #1;
        n_checks++; if (bus.lb_in_valid !== 4'b0001) $display("FAIL reset_wr_sel: got %b expected 0001", bus.lb_in_valid); else n_pass++;
        bus.pixel_in_valid = 1'b0;
    endtask

    task automatic test_write_steering;
        int b0, i0, c24;
        do_reset();
        b0 = rec_q.size();
        i0 = intr_cnt;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            bus.pixel_in       = 8'(k);
            bus.pixel_in_valid = 1'b1;
            #1;
            n_checks++;
            if (bus.lb_in_valid !== 4'(1 << (k / 8)))
                $display("FAIL steer_lb_in_valid pixel %0d: got %b expected %b", k, bus.lb_in_valid, 4'(1 << (k / 8)));
            else n_pass++;
        end
        @(negedge clk);
        bus.pixel_in_valid = 1'b0;
        c24 = cyc;
        n_checks++; if (bus.pixel_window_valid !== 1'b0) $display("FAIL steer_valid_early: got %b expected 0", bus.pixel_window_valid); else n_pass++;
        step(12);
        n_checks++; if (rec_q.size() - b0 !== 8) $display("FAIL steer_window_count: got %0d expected 8", rec_q.size() - b0); else n_pass++;
        if (rec_q.size() >= b0 + 8) begin
            for (int j = 0; j < 8; j++) begin
                n_checks++; if (rec_q[b0+j].cyc !== c24 + 1 + j) $display("FAIL steer_window_cycle %0d: got %0d expected %0d", j, rec_q[b0+j].cyc, c24 + 1 + j); else n_pass++;
                n_checks++; if (rec_q[b0+j].rd !== 4'b0111) $display("FAIL steer_lb_read %0d: got %b expected 0111", j, rec_q[b0+j].rd); else n_pass++;
                n_checks++; if (rec_q[b0+j].px !== exp_px(0, 0, j)) $display("FAIL steer_window_px %0d: got %h expected %h", j, rec_q[b0+j].px, exp_px(0, 0, j)); else n_pass++;
            end
        end
        n_checks++; if (intr_cnt - i0 !== 1) $display("FAIL steer_intr_count: got %0d expected 1", intr_cnt - i0); else n_pass++;
        n_checks++; if (intr_cyc_q[$] !== c24 + 9) $display("FAIL steer_intr_cycle: got %0d expected %0d", intr_cyc_q[$], c24 + 9); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int b0, i0, c32, ec;
        do_reset();
        b0 = rec_q.size();
        i0 = intr_cnt;
        feed(32, 0);
        c32 = cyc;
        step(16);
        n_checks++; if (rec_q.size() - b0 !== 16) $display("FAIL b2b_window_count: got %0d expected 16", rec_q.size() - b0); else n_pass++;
        if (rec_q.size() >= b0 + 16) begin
            for (int n = 0; n < 16; n++) begin
                ec = (n < 8) ? (c32 - 7 + n) : (c32 + 2 + (n - 8));
                n_checks++; if (rec_q[b0+n].cyc !== ec) $display("FAIL b2b_window_cycle %0d: got %0d expected %0d", n, rec_q[b0+n].cyc, ec); else n_pass++;
                n_checks++; if (rec_q[b0+n].rd !== exp_rd(n / 8)) $display("FAIL b2b_lb_read %0d: got %b expected %b", n, rec_q[b0+n].rd, exp_rd(n / 8)); else n_pass++;
                n_checks++; if (rec_q[b0+n].px !== exp_px(0, n / 8, n % 8)) $display("FAIL b2b_window_px %0d: got %h expected %h", n, rec_q[b0+n].px, exp_px(0, n / 8, n % 8)); else n_pass++;
            end
        end
        n_checks++; if (intr_cnt - i0 !== 2) $display("FAIL b2b_intr_count: got %0d expected 2", intr_cnt - i0); else n_pass++;
    endtask

    task automatic test_rotation;
        int b0, i0;
        bit seen;
        do_reset();
        b0 = rec_q.size();
        i0 = intr_cnt;
        feed(32, 0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.line_done_intr === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL rot_first_intr: got none expected pulse within 20 cycles"); else n_pass++;
        feed(8, 32);
        step(25);
        n_checks++; if (rec_q.size() - b0 !== 24) $display("FAIL rot_window_count: got %0d expected 24", rec_q.size() - b0); else n_pass++;
        if (rec_q.size() >= b0 + 24) begin
            for (int n = 0; n < 24; n++) begin
                n_checks++; if (rec_q[b0+n].rd !== exp_rd(n / 8)) $display("FAIL rot_lb_read %0d: got %b expected %b", n, rec_q[b0+n].rd, exp_rd(n / 8)); else n_pass++;
                n_checks++; if (rec_q[b0+n].px !== exp_px(0, n / 8, n % 8)) $display("FAIL rot_window_px %0d: got %h expected %h", n, rec_q[b0+n].px, exp_px(0, n / 8, n % 8)); else n_pass++;
            end
        end
        n_checks++; if (intr_cnt - i0 !== 3) $display("FAIL rot_intr_count: got %0d expected 3", intr_cnt - i0); else n_pass++;
    endtask

    task automatic test_reset_mid_read;
        int b1, i0;
        bit seen;
        do_reset();
        feed(24, 0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.pixel_window_valid === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL mid_read_start: got none expected READ within 10 cycles"); else n_pass++;
        step(3);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.pixel_window_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b expected 0", bus.pixel_window_valid); else n_pass++;
        n_checks++; if (bus.lb_read !== 4'b0000) $display("FAIL mid_reset_lb_read: got %b expected 0000", bus.lb_read); else n_pass++;
        n_checks++; if (bus.line_done_intr !== 1'b0) $display("FAIL mid_reset_intr: got %b expected 0", bus.line_done_intr); else n_pass++;
        reset = 1'b0;
        i0 = intr_cnt;
        b1 = rec_q.size();
        step(10);
        n_checks++; if (intr_cnt !== i0) $display("FAIL mid_reset_no_intr: got %0d pulses expected 0", intr_cnt - i0); else n_pass++;
        n_checks++; if (rec_q.size() !== b1) $display("FAIL mid_reset_no_read: got %0d windows expected 0", rec_q.size() - b1); else n_pass++;
        feed(24, 64);
        step(12);
        n_checks++; if (rec_q.size() - b1 !== 8) $display("FAIL fresh_window_count: got %0d expected 8", rec_q.size() - b1); else n_pass++;
        if (rec_q.size() >= b1 + 8) begin
            for (int j = 0; j < 8; j++) begin
                n_checks++; if (rec_q[b1+j].rd !== 4'b0111) $display("FAIL fresh_lb_read %0d: got %b expected 0111", j, rec_q[b1+j].rd); else n_pass++;
                n_checks++; if (rec_q[b1+j].px !== exp_px(64, 0, j)) $display("FAIL fresh_window_px %0d: got %h expected %h", j, rec_q[b1+j].px, exp_px(64, 0, j)); else n_pass++;
            end
        end
        n_checks++; if (intr_cnt - i0 !== 1) $display("FAIL fresh_intr_count: got %0d expected 1", intr_cnt - i0); else n_pass++;
    endtask

    initial begin
        reset              = 1'b1;
        bus.pixel_in       = 8'h00;
        bus.pixel_in_valid = 1'b0;
        test_reset();
        test_write_steering();
        test_back_to_back();
        test_rotation();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/line_buffer_control.md
Name: line_buffer_control

Overview:
- Sequencer for four external `data_buffer` line buffers (lines 0–3) in the 3x3 image-filter front end.
- Steers the incoming pixel stream into one line buffer at a time.
- Once three full lines are stored, reads three adjacent buffers in lockstep and presents a 72-bit 3-row pixel column to the filter/MAC stage.
- Pulses an interrupt each time one output line has been read, so the DMA/host can feed the next input line.

Parameters:
IMAGE_WIDTH, 512, pixels per image line; also the depth of each line buffer.
IW_BIT_NUM, 9, width of the per-line pixel counters; requires 2^IW_BIT_NUM >= IMAGE_WIDTH.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
pixel_in  input  8  incoming pixel, forwarded unchanged to every line buffer's data_in_pixel.
pixel_in_valid  input  1  pixel_in is valid this cycle; there is no backpressure.
lb_in_valid  output  4  per-buffer write strobe (bit i drives buffer i's data_in_valid).
lb_read  output  4  per-buffer read advance (bit i drives buffer i's data_out_read).
lb_data0, lb_data1, lb_data2, lb_data3  input  24 each  3-pixel outputs of buffers 0–3.
pixel_window  output  72  {row_top[23:0], row_mid[23:0], row_bot[23:0]}.
pixel_window_valid  output  1  pixel_window is valid this cycle.
line_done_intr  output  1  one-cycle pulse after a full output line has been read.

Behaviour:
- Reset: every register is cleared on a rising clk edge with reset=1.
  - wr_cnt=0, wr_sel=0, rd_cnt=0, rd_sel=0, total_cnt=0, state=IDLE, line_done_intr=0.
  - lb_in_valid, lb_read and pixel_window_valid are therefore 0.
  - Line-buffer contents are not cleared; after reset they are treated as stale.
  - A reset mid-line or mid-read abandons that line with no interrupt.
- Write side:
  - lb_in_valid[i] = pixel_in_valid && (wr_sel==i). This is combinational, with zero latency.
  - wr_cnt increments on each pixel_in_valid.
  - When pixel_in_valid and wr_cnt==IMAGE_WIDTH-1: wr_cnt returns to 0 and wr_sel advances by 1 modulo 4 (3 wraps to 0).
- Occupancy counter total_cnt (IW_BIT_NUM+3 bits) holds pixels written but not yet read:
  - +1 on a write only.
  - -1 on a read cycle only.
  - Unchanged when a write and a read occur in the same cycle.
- Read FSM, two states:
  - IDLE → READ when total_cnt >= 3*IMAGE_WIDTH, evaluated on the registered value.
  - READ: each cycle in READ is one read; rd_cnt increments.
  - When rd_cnt==IMAGE_WIDTH-1: rd_cnt→0, rd_sel advances modulo 4, state→IDLE, and line_done_intr is registered high for exactly the next cycle.
  - READ is never exited early.
  - The FSM may re-enter READ on the cycle after returning to IDLE if occupancy still allows.
- Read outputs:
  - Rows in use: top = rd_sel, mid = (rd_sel+1) mod 4, bot = (rd_sel+2) mod 4.
  - lb_read[i] = (state==READ) && i is one of those three rows. Exactly 3 bits are set during READ and 0 bits in IDLE.
  - pixel_window = {lb_data[top], lb_data[mid], lb_data[bot]}, selected combinationally.
  - pixel_window_valid = (state==READ), asserted in the same cycle as lb_read.
  - Each line produces IMAGE_WIDTH windows. The last two windows of each line contain wrapped pixels; the downstream stage discards them.
- Upstream contract (not enforced):
  - total_cnt must never exceed 4*IMAGE_WIDTH.
  - Upstream must not send a 4th line beyond the unread ones until line_done_intr fires.
  - Violations corrupt data but cannot hang the FSM.

Test Plan:
- Reset check, IMAGE_WIDTH=8: assert reset 2 cycles → all outputs 0, state IDLE; pixel_in_valid held high during reset → no lb_in_valid bit is set.
- Write steering: stream 24 pixels of values 0..23 continuously → lb_in_valid is 4'b0001 for pixels 0–7, 4'b0010 for 8–15, 4'b0100 for 16–23. pixel_window_valid first rises the cycle after the 24th write edge and stays high 8 cycles; lb_read==4'b0111; line_done_intr pulses once after the 8th read.
- Window content: after the test above, row top/mid/bot pixel 0 equals 0/8/16 in pixel_window[71:64], [47:40] and [23:16] on the first valid cycle.
- Rotation: stream 5 full lines → second read line uses lb_read=4'b1110 and third uses 4'b1101 with top=buffer 2; exactly 3 line_done_intr pulses in total.
- Simultaneous write/read: feed line 4 while line 1 is being read → total_cnt unchanged on overlap cycles; second READ starts immediately after the first with no IDLE gap beyond 1 cycle.
- Reset mid-READ at rd_cnt=3 → next cycle is IDLE, lb_read=0, no line_done_intr, and a fresh 3-line stream yields correct windows starting at buffer 0.
